// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the R-format execute unit.
//   - default datapath width and register count
//   - ALU operation encodings (alu_op_e)
//   - helper identifying ops that can raise signed overflow
package exec_pkg;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_REG_COUNT = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  // Only ADD and SUB report signed overflow; every other op forces it low.
  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_unit.sv
// alu_unit: purely combinational R-format ALU.
// Ports:
//   a, b    : DATA_W operands (b is the second source / shift amount)
//   op      : operation select (exec_pkg::alu_op_e)
//   result  : DATA_W result, wraps modulo 2^DATA_W
//   ovf     : signed overflow, meaningful only for ADD/SUB, 0 otherwise
module alu_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;
  logic [SH_W-1:0]   shamt_s;
  logic              add_ovf_s;
  logic              sub_ovf_s;

  // Operation mux plus overflow detection from operand/result sign bits.
  always_comb begin
    sum_s     = a + b;
    diff_s    = a - b;
    shamt_s   = b[SH_W-1:0];
    result    = {DATA_W{1'b0}};
    // Overflow when like-signed operands (ADD) or unlike-signed (SUB)
    // produce a result whose sign differs from a.
    add_ovf_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
    sub_ovf_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);

    case (op)
      OP_ADD:  result = sum_s;
      OP_SUB:  result = diff_s;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                  : {DATA_W{1'b0}};
      OP_SLL:  result = a << shamt_s;
      OP_SRL:  result = a >> shamt_s;
      default: result = {DATA_W{1'b0}};
    endcase

    if (!is_arith(op)) begin
      ovf = 1'b0;
    end else if (op == OP_ADD) begin
      ovf = add_ovf_s;
    end else begin
      ovf = sub_ovf_s;
    end
  end

endmodule

// File: rtl/rformat_exec_unit.sv
// rformat_exec_unit: two-stage (EX -> WB) R-format execute unit with its
// own register file.
// Ports:
//   clk, reset_input          : clock, asynchronous active-low reset
//   in_valid / in_ready       : issue handshake
//   rs/rt/rd_address          : sources A, B and destination register
//   ALU_operation             : operation select (exec_pkg::alu_op_e)
//   ext_we/ext_waddr/ext_wdata: external register preload port
//   result_valid/result_ready : retire handshake of the WB stage
//   out_data/out_address      : WB result and its destination
//   zero_flag, ovf_flag       : out_data == 0, signed overflow of ADD/SUB
//   dbg_address / dbg_data    : combinational register-file read, no bypass
module rformat_exec_unit
  import exec_pkg::*;
#(
  parameter  int DATA_W    = DEFAULT_DATA_W,
  parameter  int REG_COUNT = DEFAULT_REG_COUNT,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset_input,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_address,
  input  logic [ADDR_W-1:0] rt_address,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic [2:0]        ALU_operation,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_address,
  output logic              zero_flag,
  output logic              ovf_flag,
  input  logic [ADDR_W-1:0] dbg_address,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [REG_COUNT];

  logic              result_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ADDR_W-1:0] out_address_r;
  logic              zero_r;
  logic              ovf_r;

  logic              issue_s;
  logic              retire_s;
  logic              ext_wr_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_ovf_s;

  assign in_ready     = !result_valid_r || result_ready;
  assign result_valid = result_valid_r;
  assign out_data     = out_data_r;
  assign out_address  = out_address_r;
  assign zero_flag    = zero_r;
  assign ovf_flag     = ovf_r;

  // Handshake decode; an ext write colliding with a same-edge retire is dropped.
  always_comb begin
    issue_s  = in_valid && in_ready;
    retire_s = result_valid_r && result_ready;
    ext_wr_s = ext_we && (ext_waddr != ZERO_ADDR) &&
               !(retire_s && (out_address_r == ext_waddr));
  end

  // Operand read: r0 is hard zero, a pending WB result to a nonzero
  // register is forwarded so back-to-back dependent ops see program order.
  always_comb begin
    if (rs_address == ZERO_ADDR) begin
      op_a_s = {DATA_W{1'b0}};
    end else if (result_valid_r && (out_address_r == rs_address)) begin
      op_a_s = out_data_r;
    end else begin
      op_a_s = regs_r[rs_address];
    end

    if (rt_address == ZERO_ADDR) begin
      op_b_s = {DATA_W{1'b0}};
    end else if (result_valid_r && (out_address_r == rt_address)) begin
      op_b_s = out_data_r;
    end else begin
      op_b_s = regs_r[rt_address];
    end
  end

  // Debug read shows committed register contents only.
  always_comb begin
    if (dbg_address == ZERO_ADDR) begin
      dbg_data = {DATA_W{1'b0}};
    end else begin
      dbg_data = regs_r[dbg_address];
    end
  end

  alu_unit #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (op_a_s),
    .b      (op_b_s),
    .op     (alu_op_e'(ALU_operation)),
    .result (alu_res_s),
    .ovf    (alu_ovf_s)
  );

  // Register file: written only on retire or by the preload port, never r0.
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (retire_s && (out_address_r != ZERO_ADDR)) begin
        regs_r[out_address_r] <= out_data_r;
      end
      if (ext_wr_s) begin
        regs_r[ext_waddr] <= ext_wdata;
      end
    end
  end

  // WB stage: load on issue, empty on retire without a new issue, otherwise
  // hold everything stable (stall while the consumer is not ready).
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      result_valid_r <= 1'b0;
      out_data_r     <= {DATA_W{1'b0}};
      out_address_r  <= ZERO_ADDR;
      zero_r         <= 1'b1;
      ovf_r          <= 1'b0;
    end else if (issue_s) begin
      result_valid_r <= 1'b1;
      out_data_r     <= alu_res_s;
      out_address_r  <= rd_address;
      zero_r         <= (alu_res_s == {DATA_W{1'b0}});
      ovf_r          <= alu_ovf_s;
    end else if (retire_s) begin
      result_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rformat_exec_unit.sv
module tb_rformat_exec_unit;

  logic        clk = 1'b0;
  logic        reset_input;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_address, rt_address, rd_address;
  logic [2:0]  ALU_operation;
  logic        ext_we;
  logic [4:0]  ext_waddr;
  logic [31:0] ext_wdata;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] out_data;
  logic [4:0]  out_address;
  logic        zero_flag, ovf_flag;
  logic [4:0]  dbg_address;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  // Reference state: committed registers plus the pending (WB) result.
  logic [31:0] ref_regs [32];
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [4:0]  exp_addr;
  logic        exp_ovf;

  rformat_exec_unit dut (
    .clk           (clk),
    .reset_input   (reset_input),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rs_address    (rs_address),
    .rt_address    (rt_address),
    .rd_address    (rd_address),
    .ALU_operation (ALU_operation),
    .ext_we        (ext_we),
    .ext_waddr     (ext_waddr),
    .ext_wdata     (ext_wdata),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .out_data      (out_data),
    .out_address   (out_address),
    .zero_flag     (zero_flag),
    .ovf_flag      (ovf_flag),
    .dbg_address   (dbg_address),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Specification-level ALU: plain arithmetic on integers.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, output logic ovf);
    longint sa, sb, s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    case (op)
      0: begin s = sa + sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a + b; end
      1: begin s = sa - sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a - b; end
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sa < sb) ? 32'd1 : 32'd0;
      6: return a << (b % 32);
      7: return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    exp_valid = 1'b0; exp_data = 32'd0; exp_addr = 5'd0; exp_ovf = 1'b0;
  endtask

  // One clock: update the model from the current inputs, take the edge,
  // then compare every output against the model.
  task automatic step();
    logic [31:0] view [32];
    logic        retire, issue, novf;
    logic [31:0] nres;
    // Program-order view: committed state overlaid with the pending result.
    for (int i = 0; i < 32; i++) view[i] = ref_regs[i];
    if (exp_valid && exp_addr != 5'd0) view[exp_addr] = exp_data;
    view[0] = 32'd0;
    retire = exp_valid && result_ready;
    issue  = in_valid && (!exp_valid || result_ready);
    nres   = ref_alu(int'(ALU_operation), view[rs_address], view[rt_address], novf);
    if (retire && exp_addr != 5'd0) ref_regs[exp_addr] = exp_data;
    if (ext_we && ext_waddr != 5'd0 && !(retire && exp_addr == ext_waddr))
      ref_regs[ext_waddr] = ext_wdata;
    if (issue) begin
      exp_valid = 1'b1; exp_data = nres; exp_addr = rd_address; exp_ovf = novf;
    end else if (retire) begin
      exp_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("valid", result_valid, exp_valid);
    chk("data",  out_data,     exp_data);
    chk("addr",  out_address,  exp_addr);
    chk("zero",  zero_flag,    exp_data == 32'd0);
    chk("ovf",   ovf_flag,     exp_ovf);
    chk("ready", in_ready,     !exp_valid || result_ready);
    chk("dbg",   dbg_data,     (dbg_address == 5'd0) ? 32'd0 : ref_regs[dbg_address]);
  endtask

  task automatic ext_wr(input logic [4:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    step();
    ext_we = 1'b0;
  endtask

  task automatic issue_op(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic rdy);
    in_valid = 1'b1; ALU_operation = op; rs_address = rs; rt_address = rt; rd_address = rd;
    result_ready = rdy;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_input = 1'b0; in_valid = 1'b0; rs_address = 5'd0; rt_address = 5'd0;
    rd_address = 5'd0; ALU_operation = 3'd0; ext_we = 1'b0; ext_waddr = 5'd0;
    ext_wdata = 32'd0; result_ready = 1'b1; dbg_address = 5'd5;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_addr",  out_address, 5'd0);
    chk("rst_zero",  zero_flag, 1'b1);
    chk("rst_ovf",   ovf_flag, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_dbg",   dbg_data, 32'd0);
    reset_input = 1'b1;
    step();

    // Preload and simple ADD
    ext_wr(5'd1, 32'd31);
    ext_wr(5'd2, 32'd47);
    issue_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    chk("add_data", out_data, 32'd78);
    chk("add_addr", out_address, 5'd3);
    dbg_address = 5'd3;
    step();
    chk("add_dbg", dbg_data, 32'd78);

    // Back-to-back dependent ops through the bypass
    issue_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    issue_op(3'd1, 5'd3, 5'd1, 5'd4, 1'b1);
    chk("byp_data", out_data, 32'd47);
    dbg_address = 5'd4;
    step();
    chk("byp_dbg", dbg_data, 32'd47);

    // Write to r0 discarded; SUB overflow
    dbg_address = 5'd0;
    issue_op(3'd0, 5'd1, 5'd2, 5'd0, 1'b1);
    chk("r0_valid", result_valid, 1'b1);
    chk("r0_data", out_data, 32'd78);
    step();
    chk("r0_dbg", dbg_data, 32'd0);
    ext_wr(5'd6, 32'h8000_0000);
    ext_wr(5'd7, 32'd1);
    issue_op(3'd1, 5'd6, 5'd7, 5'd8, 1'b1);
    chk("sub_ovf_data", out_data, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", ovf_flag, 1'b1);
    step();

    // Stall: result held, no issue accepted, no register write
    dbg_address = 5'd7;
    issue_op(3'd0, 5'd1, 5'd2, 5'd7, 1'b0);
    in_valid = 1'b1; ALU_operation = 3'd1; rs_address = 5'd1; rt_address = 5'd2; rd_address = 5'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_data", out_data, 32'd78);
      chk("stall_addr", out_address, 5'd7);
      chk("stall_dbg", dbg_data, 32'd1);
    end
    in_valid = 1'b0; result_ready = 1'b1;
    step();
    chk("stall_retire_valid", result_valid, 1'b0);
    chk("stall_retire_ready", in_ready, 1'b1);
    chk("stall_retire_dbg", dbg_data, 32'd78);
    step();

    // Same-edge retire and ext write to r5: retire wins
    dbg_address = 5'd5;
    issue_op(3'd0, 5'd1, 5'd2, 5'd5, 1'b0);
    result_ready = 1'b1;
    ext_wr(5'd5, 32'd9);
    chk("collide_dbg", dbg_data, 32'd78);

    // SLT signed and SRL
    ext_wr(5'd9, 32'hFFFF_FFFF);
    ext_wr(5'd10, 32'd1);
    issue_op(3'd5, 5'd9, 5'd10, 5'd11, 1'b1);
    chk("slt", out_data, 32'd1);
    ext_wr(5'd12, 32'd31);
    issue_op(3'd7, 5'd6, 5'd12, 5'd14, 1'b1);
    chk("srl", out_data, 32'd1);
    step();

    // Reset mid-operation: WB discarded, destination untouched
    issue_op(3'd0, 5'd1, 5'd2, 5'd13, 1'b0);
    chk("pre_rst_valid", result_valid, 1'b1);
    #2;
    reset_input = 1'b0;
    #1;
    chk("mid_rst_valid", result_valid, 1'b0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_addr", out_address, 5'd0);
    chk("mid_rst_zero", zero_flag, 1'b1);
    chk("mid_rst_ready", in_ready, 1'b1);
    model_reset();
    @(posedge clk); #1;
    reset_input = 1'b1; result_ready = 1'b1; dbg_address = 5'd13;
    #1;
    chk("mid_rst_dbg13", dbg_data, 32'd0);
    step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      ALU_operation = 3'($urandom_range(0, 7));
      rs_address    = 5'($urandom_range(0, 7));
      rt_address    = 5'($urandom_range(0, 7));
      rd_address    = 5'($urandom_range(0, 7));
      result_ready  = ($urandom_range(0, 3) != 0);
      ext_we        = ($urandom_range(0, 3) == 0);
      ext_waddr     = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       ext_wdata = 32'h8000_0000;
        1:       ext_wdata = 32'h7FFF_FFFF;
        2:       ext_wdata = 32'($urandom_range(0, 40));
        default: ext_wdata = $urandom;
      endcase
      dbg_address   = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rformat_exec_unit.md
RFORMAT_EXEC_UNIT -- requirements
Module: rformat_exec_unit

Interface
REQ-001 Parameter DATA_W, default 32, meaning datapath and register width in bits (8..64).
REQ-002 Parameter REG_COUNT, default 32, meaning number of architectural registers (power of two, 4..64); ADDR_W = log2(REG_COUNT).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_input  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  issue request carries a valid R-format operation.
REQ-006 in_ready  output  1  unit accepts the issue this cycle; transfer when in_valid && in_ready.
REQ-007 rs_address, rt_address, rd_address  input  ADDR_W each  source A, source B and destination register.
REQ-008 ALU_operation  input  3  operation select.
REQ-009 ext_we, ext_waddr, ext_wdata  input  1/ADDR_W/DATA_W  external register preload port.
REQ-010 result_valid  output  1  result stage holds a completed operation.
REQ-011 result_ready  input  1  consumer accepts the result; retire when result_valid && result_ready.
REQ-012 out_data, out_address  output  DATA_W/ADDR_W  result value and its destination.
REQ-013 zero_flag, ovf_flag  output  1 each  out_data == 0; signed overflow of ADD/SUB.
REQ-014 dbg_address  input  ADDR_W; dbg_data  output  DATA_W  combinational register-file read.

Function
REQ-015 ALU_operation encodings: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL A by B[log2(DATA_W)-1:0], 111 SRL (logical), same shift rule.
REQ-016 Arithmetic wraps modulo 2^DATA_W; ovf_flag is 0 for all ops other than ADD/SUB.
REQ-017 Two stages: EX (operand read plus ALU, combinational from accepted inputs) and WB (result register); issue accepted at edge k gives result_valid high in cycle k+1.
REQ-018 Register file writes out_data to out_address at the edge where the result retires; it does not write earlier.
REQ-019 Bypass: if WB holds a valid result whose out_address equals the rs or rt address being issued (nonzero), the EX operand uses out_data instead of the register-file value.
REQ-020 Register 0 reads as zero always; a retire or ext write to address 0 is discarded; no bypass from address 0.
REQ-021 in_ready = !result_valid || result_ready; when result_valid && !result_ready, WB holds all outputs stable and no issue is accepted.
REQ-022 Simultaneous retire and issue: retire writes the register file and the new result loads WB in the same edge (full throughput, one op per cycle).
REQ-023 ext write applies at the edge; same-edge retire to same address wins, ext write dropped; an ext write is not bypassed to a same-cycle issue (issue reads the old value).
REQ-024 dbg_data reflects register contents only (no bypass), with register 0 = 0.

Reset
REQ-025 While reset_input is low: all registers = 0, result_valid = 0, out_data = 0, out_address = 0, zero_flag = 1, ovf_flag = 0, in_ready = 1.
REQ-026 Reset asserted mid-operation discards the WB content without writing the register file.

Structure
REQ-027 Package exec_pkg holds ALU op encodings, default DATA_W/REG_COUNT, and the op-code typedef.
REQ-028 One sub-module alu_unit (parametrised DATA_W, combinational: A, B, op -> result, ovf); register file and pipeline control stay in rformat_exec_unit.

Verification
REQ-029 ext write r1=31, r2=47; issue ADD rs=1 rt=2 rd=3 with result_ready=1 -> next cycle out_data=78, out_address=3; then dbg_address=3 -> dbg_data=78.
REQ-030 Back-to-back: ADD r3=r1+r2, then next cycle SUB r4=r3-r1 -> second result 47 (bypass used); dbg r4=47 after retire.
REQ-031 ADD rd=0 with result 78 -> result_valid pulses, dbg r0 stays 0; SUB 0x80000000 - 1 -> out_data 0x7FFFFFFF, ovf_flag=1.
REQ-032 result_ready=0 for 3 cycles with result pending -> in_ready=0, outputs stable, no register write; ready=1 -> single retire, in_ready=1.
REQ-033 Same-edge retire to r5 and ext write r5=9 -> r5 holds the ALU result; SLT -1 vs 1 -> 1; SRL 0x80000000 by 31 -> 1.
REQ-034 Assert reset_input low while result_valid=1 -> outputs at reset values immediately, destination register unchanged (0).
